multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
- Parametrised, clocked successor to the datapath ALU.
- Single-cycle logic and arithmetic ops produce a registered result one cycle after acceptance.
- MULT and DIV run iteratively over WIDTH cycles and deliver a full-width HI/LO pair (product high/low, remainder/quotient).
- Sits in the execute stage behind a start/ready handshake so the pipeline can stall on long ops.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- SIGNED_SLT, 0, 0 = SLT compares unsigned, 1 = SLT compares two's-complement.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted on a rising edge when start && in_ready.
- in_ready  out  1  block can accept a request this cycle.
- selector  in  6  opcode, sampled on acceptance.
- input1  in  WIDTH  operand A, sampled on acceptance.
- input2  in  WIDTH  operand B, sampled on acceptance.
- out_valid  out  1  one-cycle pulse: result/hi/flags are updated this cycle.
- result  out  WIDTH  primary result (LO for MULT, quotient for DIV).
- hi  out  WIDTH  product high half (MULT) or remainder (DIV); 0 for other ops.
- zero  out  1  result == 0, registered together with result.
- div_by_zero  out  1  set with the result of a DIV whose input2 == 0.
- illegal_op  out  1  set with the result of an unrecognised selector.

Behaviour:
- Opcodes:
  - ADD 100000, SUB 100010, MULT 011000, DIV 011010.
  - AND 100100, OR 100101, NOR 100111, XOR 100110.
  - SLT 101010, EQ 111111.
  - All other codes are illegal.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - MULT and DIV are unsigned.
  - SLT and EQ return 1 or 0 zero-extended to WIDTH.
- Reset (async, active-high): state IDLE; in_ready=1; out_valid=0; result, hi, zero, div_by_zero and illegal_op all 0.
  - A reset asserted mid-iteration aborts the operation; no out_valid is produced.
- FSM states: IDLE, MUL, DIV.
  - IDLE: in_ready=1.
  - Accepting MULT with WIDTH>0 goes to MUL. Accepting DIV with input2!=0 goes to DIV. Every other accepted op stays in IDLE.
  - MUL: shift-add, one multiplier bit per cycle; a down-counter runs from WIDTH-1 to 0. In_ready=0.
  - DIV: restoring division, one quotient bit per cycle; same counter. In_ready=0.
  - MUL and DIV return to IDLE on the cycle their counter reaches 0.
- Latency is measured from the acceptance edge N.
  - Single-cycle ops, DIV-by-zero and illegal ops: outputs update and out_valid pulses at edge N+1. In_ready stays 1, so back-to-back accepts give one result per cycle.
  - MULT/DIV: outputs update and out_valid pulses at edge N+WIDTH. In_ready is 0 from edge N+1 and returns to 1 at edge N+WIDTH. A new start may be accepted on edge N+WIDTH.
- start while in_ready=0: ignored; no queuing.
- Operands are latched at acceptance. Later changes on input1/input2/selector do not affect an in-flight op.
- DIV by zero: result all ones, hi = input1, div_by_zero=1, no iteration.
- Illegal op: result=0, hi=0, illegal_op=1, so zero=1.
- Flags div_by_zero and illegal_op are cleared by the next completion that does not set them.
- Outputs hold their values between completions. out_valid is high for exactly one cycle per accepted op.
- There is no output backpressure; the consumer must capture on out_valid.
- No X is ever driven on any output.

Decomposition:
- Shared package alu_pkg holds:
  - localparam opcode constants (OP_ADD .. OP_EQ).
  - The FSM state typedef {IDLE, MUL, DIV}.
- One natural sub-module: alu_muldiv_iter.
  - Owns the counter, accumulator and the shift-add / restoring-divide datapath.
  - Interface: go, is_div, a, b in; done, lo, hi out.
- The top module keeps the combinational single-cycle ops, flag logic and the handshake.

Test Plan:
- WIDTH=32. Back-to-back ADD 0xFFFFFFFF+1, SUB 5-7, then EQ 9,9 on consecutive cycles:
  - Three consecutive out_valid pulses.
  - Results 0 (zero=1), 0xFFFFFFFE, then 1.
  - in_ready stays 1 throughout.
- MULT 0xFFFFFFFF*0xFFFFFFFF accepted at edge N:
  - in_ready=0 for 32 cycles.
  - out_valid at N+32 with hi=0xFFFFFFFE, result=0x00000001.
  - A start pulsed mid-op is ignored.
- DIV 100/7:
  - out_valid at N+32, result=14, hi=2, div_by_zero=0.
- DIV 100/0:
  - out_valid at N+1, result=0xFFFFFFFF, hi=100, div_by_zero=1.
  - A following ADD 1+1 yields 2 with div_by_zero=0.
- SLT with input1=0xFFFFFFFF, input2=1:
  - SIGNED_SLT=0 gives result 0.
  - SIGNED_SLT=1 gives result 1.
- WIDTH=8. Start MULT 0x10*0x10, assert reset at N+3:
  - All outputs 0 immediately, with no clock edge needed.
  - No out_valid is produced afterwards.
  - After reset, selector 000000 gives illegal_op=1, result=0, zero=1 at N+1.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode constants and FSM state encoding shared by the multicycle ALU files.
// Pure declarations: no latency, no flow control.
package alu_pkg;

   localparam logic [5:0] OP_ADD  = 6'b100000;
   localparam logic [5:0] OP_SUB  = 6'b100010;
   localparam logic [5:0] OP_MULT = 6'b011000;
   localparam logic [5:0] OP_DIV  = 6'b011010;
   localparam logic [5:0] OP_AND  = 6'b100100;
   localparam logic [5:0] OP_OR   = 6'b100101;
   localparam logic [5:0] OP_NOR  = 6'b100111;
   localparam logic [5:0] OP_XOR  = 6'b100110;
   localparam logic [5:0] OP_SLT  = 6'b101010;
   localparam logic [5:0] OP_EQ   = 6'b111111;

   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t MUL  = 2'd1;
   localparam state_t DIV  = 2'd2;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Latency WIDTH cycles from go; done is combinational in the last cycle, lo/hi are that step's results.
module alu_muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             go,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int CW = $clog2(WIDTH);

   logic             busy;
   logic             div_q;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] sh_q;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem2;
   logic [WIDTH:0]   diff;
   logic             qbit;

   // Multiply: acc_q:sh_q is the product register, sh_q starts as the multiplier.
   // Divide: acc_q is the partial remainder, sh_q shifts the dividend out and the quotient in.
   always_comb begin
      sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, m_q} : '0);
      rem2 = {acc_q, sh_q[WIDTH-1]};
      diff = rem2 - {1'b0, m_q};
      qbit = ~diff[WIDTH];
      if (div_q) begin
         hi = qbit ? diff[WIDTH-1:0] : rem2[WIDTH-1:0];
         lo = {sh_q[WIDTH-2:0], qbit};
      end else begin
         hi = sum[WIDTH:1];
         lo = {sum[0], sh_q[WIDTH-1:1]};
      end
   end

   assign done = busy && (cnt == '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy  <= 1'b0;
         div_q <= 1'b0;
         cnt   <= '0;
         m_q   <= '0;
         acc_q <= '0;
         sh_q  <= '0;
      end else if (go) begin
         busy  <= 1'b1;
         div_q <= is_div;
         cnt   <= CW'(WIDTH - 1);
         m_q   <= is_div ? b : a;
         sh_q  <= is_div ? a : b;
         acc_q <= '0;
      end else if (busy) begin
         acc_q <= hi;
         sh_q  <= lo;
         cnt   <= cnt - 1'b1;
         if (cnt == '0) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle ops registered one cycle after accept, MULT/DIV after WIDTH cycles.
// in_ready drops while MULT/DIV iterate (start is ignored, not queued); no output backpressure.
module multicycle_alu
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter bit SIGNED_SLT = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   output logic             in_ready,
   input  logic [5:0]       selector,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             div_by_zero,
   output logic             illegal_op
);

   state_t           state;
   logic             pend;
   logic             accept;
   logic             go;
   logic             done;
   logic             lt;
   logic [5:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] it_lo;
   logic [WIDTH-1:0] it_hi;
   logic [WIDTH-1:0] s_res;
   logic [WIDTH-1:0] s_hi;
   logic             s_dz;
   logic             s_il;

   // Ready again in the final iteration cycle so a new op can be taken on the completion edge.
   assign in_ready = (state == IDLE) || done;
   assign accept   = start && in_ready;
   assign go       = accept && ((selector == OP_MULT) ||
                                ((selector == OP_DIV) && (input2 != '0)));

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clock  (clock),
      .reset  (reset),
      .go     (go),
      .is_div (selector == OP_DIV),
      .a      (input1),
      .b      (input2),
      .done   (done),
      .lo     (it_lo),
      .hi     (it_hi)
   );

   always_comb begin
      if (SIGNED_SLT) lt = $signed(a_q) < $signed(b_q);
      else            lt = a_q < b_q;
   end

   // Only single-cycle ops, DIV by zero and illegal codes reach this decode.
   always_comb begin
      s_res = '0;
      s_hi  = '0;
      s_dz  = 1'b0;
      s_il  = 1'b0;
      case (op_q)
         OP_ADD: s_res = a_q + b_q;
         OP_SUB: s_res = a_q - b_q;
         OP_AND: s_res = a_q & b_q;
         OP_OR:  s_res = a_q | b_q;
         OP_NOR: s_res = ~(a_q | b_q);
         OP_XOR: s_res = a_q ^ b_q;
         OP_SLT: s_res = {{(WIDTH-1){1'b0}}, lt};
         OP_EQ:  s_res = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
         OP_DIV: begin
            s_res = '1;
            s_hi  = a_q;
            s_dz  = 1'b1;
         end
         default: s_il = 1'b1;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pend        <= 1'b0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         out_valid   <= 1'b0;
         result      <= '0;
         hi          <= '0;
         zero        <= 1'b0;
         div_by_zero <= 1'b0;
         illegal_op  <= 1'b0;
      end else begin
         out_valid <= pend || done;
         pend      <= accept && !go;
         if (accept) begin
            op_q <= selector;
            a_q  <= input1;
            b_q  <= input2;
         end
         if (go)        state <= (selector == OP_DIV) ? DIV : MUL;
         else if (done) state <= IDLE;

         if (done) begin
            result      <= it_lo;
            hi          <= it_hi;
            zero        <= (it_lo == '0);
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
         end else if (pend) begin
            result      <= s_res;
            hi          <= s_hi;
            zero        <= (s_res == '0);
            div_by_zero <= s_dz;
            illegal_op  <= s_il;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: three instances (32-bit unsigned SLT, 32-bit signed SLT, 8-bit)
// share one stimulus stream and are checked every cycle against a transaction-level model.
module tb_multicycle_alu;

   localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, MULT = 6'b011000, DIVO = 6'b011010;
   localparam logic [5:0] ANDO = 6'b100100, ORO = 6'b100101, NORO = 6'b100111, XORO = 6'b100110;
   localparam logic [5:0] SLT = 6'b101010, EQ = 6'b111111;

   typedef struct packed {
      logic [63:0] res;
      logic [63:0] hi;
      logic        z;
      logic        dz;
      logic        il;
   } out_t;

   logic        clock, reset, start;
   logic [5:0]  selector;
   logic [31:0] input1, input2;

   logic        rdy0, rdy1, rdy2, vld0, vld1, vld2;
   logic [31:0] res0, res1, hi0, hi1;
   logic [7:0]  res2, hi2;
   logic        z0, z1, z2, dz0, dz1, dz2, il0, il1, il2;

   logic        g_rdy[3], g_vld[3], g_z[3], g_dz[3], g_il[3];
   logic [63:0] g_res[3], g_hi[3];

   int n_chk = 0;
   int n_fail = 0;
   bit run_chk = 0;

   // model state
   int   cyc;
   int   wid[3] = '{32, 32, 8};
   bit   sgn[3] = '{1'b0, 1'b1, 1'b0};
   out_t exp_o[3];
   out_t pend_o[3];
   bit   exp_v[3];
   int   pend_due[3];
   int   long_due[3];

   logic [5:0] ops[10] = '{ADD, SUB, MULT, DIVO, ANDO, ORO, NORO, XORO, SLT, EQ};

   multicycle_alu #(.WIDTH(32), .SIGNED_SLT(1'b0)) u0 (
      .clock(clock), .reset(reset), .start(start), .in_ready(rdy0), .selector(selector),
      .input1(input1), .input2(input2), .out_valid(vld0), .result(res0), .hi(hi0),
      .zero(z0), .div_by_zero(dz0), .illegal_op(il0));
   multicycle_alu #(.WIDTH(32), .SIGNED_SLT(1'b1)) u1 (
      .clock(clock), .reset(reset), .start(start), .in_ready(rdy1), .selector(selector),
      .input1(input1), .input2(input2), .out_valid(vld1), .result(res1), .hi(hi1),
      .zero(z1), .div_by_zero(dz1), .illegal_op(il1));
   multicycle_alu #(.WIDTH(8), .SIGNED_SLT(1'b0)) u2 (
      .clock(clock), .reset(reset), .start(start), .in_ready(rdy2), .selector(selector),
      .input1(input1[7:0]), .input2(input2[7:0]), .out_valid(vld2), .result(res2), .hi(hi2),
      .zero(z2), .div_by_zero(dz2), .illegal_op(il2));

   assign g_rdy[0] = rdy0;  assign g_rdy[1] = rdy1;  assign g_rdy[2] = rdy2;
   assign g_vld[0] = vld0;  assign g_vld[1] = vld1;  assign g_vld[2] = vld2;
   assign g_z[0]   = z0;    assign g_z[1]   = z1;    assign g_z[2]   = z2;
   assign g_dz[0]  = dz0;   assign g_dz[1]  = dz1;   assign g_dz[2]  = dz2;
   assign g_il[0]  = il0;   assign g_il[1]  = il1;   assign g_il[2]  = il2;
   assign g_res[0] = 64'(res0); assign g_res[1] = 64'(res1); assign g_res[2] = 64'(res2);
   assign g_hi[0]  = 64'(hi0);  assign g_hi[1]  = 64'(hi1);  assign g_hi[2]  = 64'(hi2);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [63:0] mask(input int w);
      return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

   // What an op must produce, straight from the opcode table and arithmetic rules.
   function automatic out_t model(input int w, input bit s, input logic [5:0] sel,
                                  input logic [63:0] ai, input logic [63:0] bi);
      logic [63:0]  m, a, b;
      logic [127:0] p;
      longint       sa, sb;
      out_t         o;
      m = mask(w);
      a = ai & m;
      b = bi & m;
      o = '0;
      case (sel)
         ADD:  o.res = (a + b) & m;
         SUB:  o.res = (a - b) & m;
         MULT: begin
            p = {64'd0, a} * {64'd0, b};
            o.res = p[63:0] & m;
            o.hi  = 64'(p >> w) & m;
         end
         DIVO: begin
            if (b == 0) begin
               o.res = m;
               o.hi  = a;
               o.dz  = 1'b1;
            end else begin
               o.res = a / b;
               o.hi  = a % b;
            end
         end
         ANDO: o.res = a & b;
         ORO:  o.res = a | b;
         NORO: o.res = ~(a | b) & m;
         XORO: o.res = a ^ b;
         SLT: begin
            sa = a[w-1] ? longint'(a | ~m) : longint'(a);
            sb = b[w-1] ? longint'(b | ~m) : longint'(b);
            o.res = s ? 64'(sa < sb) : 64'(a < b);
         end
         EQ:   o.res = 64'(a == b);
         default: o.il = 1'b1;
      endcase
      o.z = (o.res == 0);
      return o;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Transaction model: one pending result slot per instance, plus the edge a long op ends on.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         cyc = 0;
         for (int d = 0; d < 3; d++) begin
            exp_o[d] = '0;
            pend_o[d] = '0;
            exp_v[d] = 1'b0;
            pend_due[d] = 0;
            long_due[d] = 0;
         end
      end else begin
         cyc++;
         for (int d = 0; d < 3; d++) begin
            exp_v[d] = 1'b0;
            if (pend_due[d] == cyc) begin
               exp_o[d] = pend_o[d];
               exp_v[d] = 1'b1;
               pend_due[d] = 0;
            end
            if (long_due[d] == cyc) long_due[d] = 0;
            if (start && long_due[d] == 0) begin
               pend_o[d] = model(wid[d], sgn[d], selector, 64'(input1), 64'(input2));
               if (selector == MULT || (selector == DIVO && (64'(input2) & mask(wid[d])) != 0)) begin
                  pend_due[d] = cyc + wid[d];
                  long_due[d] = pend_due[d];
               end else begin
                  pend_due[d] = cyc + 1;
               end
            end
         end
      end
   end

   always @(negedge clock) begin
      if (run_chk) begin
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("in_ready[%0d]", d), 64'(g_rdy[d]),
                64'((long_due[d] == 0) || (long_due[d] == cyc + 1)));
            chk($sformatf("out_valid[%0d]", d), 64'(g_vld[d]), 64'(exp_v[d]));
            chk($sformatf("result[%0d]", d), g_res[d], exp_o[d].res);
            chk($sformatf("hi[%0d]", d), g_hi[d], exp_o[d].hi);
            chk($sformatf("zero[%0d]", d), 64'(g_z[d]), 64'(exp_o[d].z));
            chk($sformatf("div_by_zero[%0d]", d), 64'(g_dz[d]), 64'(exp_o[d].dz));
            chk($sformatf("illegal_op[%0d]", d), 64'(g_il[d]), 64'(exp_o[d].il));
         end
      end
   end

   task automatic issue(input logic st, input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b);
      @(posedge clock);
      #1;
      start = st;
      selector = sel;
      input1 = a;
      input2 = b;
   endtask

   // Call right after issue(): edge N accepts; lat counts edges after N until out_valid on instance d.
   task automatic wait_valid(input int d, input int pulse_at, input int limit,
                             output int lat, output logic rdy_at1);
      @(posedge clock);
      #1;
      start = 1'b0;
      lat = 0;
      rdy_at1 = 1'b1;
      do begin
         @(posedge clock);
         #1;
         lat++;
         if (lat == 1) rdy_at1 = g_rdy[d];
         if (lat == pulse_at) begin
            start = 1'b1;
            selector = ADD;
            input1 = 32'd1;
            input2 = 32'd2;
         end else begin
            start = 1'b0;
         end
      end while (!g_vld[d] && lat < limit);
      start = 1'b0;
   endtask

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFFFFFF;
         3: return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      out_t p;
      int lat, npulse;
      logic r1;

      reset = 1'b1; start = 1'b0; selector = '0; input1 = '0; input2 = '0;

      // Hand-computed values pinning the model.
      p = model(32, 0, ADD, 64'hFFFFFFFF, 64'd1);
      chk("pin_add_res", p.res, 64'd0);
      chk("pin_add_zero", 64'(p.z), 64'd1);
      p = model(32, 0, SUB, 64'd5, 64'd7);
      chk("pin_sub", p.res, 64'hFFFFFFFE);
      p = model(32, 0, MULT, 64'hFFFFFFFF, 64'hFFFFFFFF);
      chk("pin_mult_lo", p.res, 64'd1);
      chk("pin_mult_hi", p.hi, 64'hFFFFFFFE);
      p = model(32, 0, DIVO, 64'd100, 64'd7);
      chk("pin_div_q", p.res, 64'd14);
      chk("pin_div_r", p.hi, 64'd2);
      p = model(32, 0, DIVO, 64'd100, 64'd0);
      chk("pin_div0", {p.res[31:0], p.hi[31:0]}, {32'hFFFFFFFF, 32'd100});
      p = model(32, 1, SLT, 64'hFFFFFFFF, 64'd1);
      chk("pin_slt_signed", p.res, 64'd1);
      p = model(8, 0, MULT, 64'h10, 64'h10);
      chk("pin_mult8", {p.hi[31:0], p.res[31:0]}, {32'd1, 32'd0});
      p = model(32, 0, 6'b000000, 64'd3, 64'd4);
      chk("pin_illegal", {61'd0, p.il, p.z, p.dz}, 64'b110);

      repeat (3) @(posedge clock);
      #1 run_chk = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("reset_in_ready", 64'(rdy0), 64'd1);
      chk("reset_out_valid", 64'(vld0), 64'd0);
      chk("reset_result", {32'd0, res0}, 64'd0);

      // Back-to-back single-cycle ops.
      issue(1'b1, ADD, 32'hFFFFFFFF, 32'd1);
      issue(1'b1, SUB, 32'd5, 32'd7);
      issue(1'b1, EQ, 32'd9, 32'd9);
      chk("b2b_add", {29'd0, vld0, z0, rdy0, res0}, {29'd0, 3'b111, 32'd0});
      issue(1'b0, ADD, 32'd0, 32'd0);
      chk("b2b_sub", {30'd0, vld0, rdy0, res0}, {30'd0, 2'b11, 32'hFFFFFFFE});
      issue(1'b0, ADD, 32'd0, 32'd0);
      chk("b2b_eq", {30'd0, vld0, rdy0, res0}, {30'd0, 2'b11, 32'd1});

      // Long multiply with an ignored start pulse in the middle.
      issue(1'b1, MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_valid(0, 5, 80, lat, r1);
      chk("mult_latency", 64'(lat), 64'd32);
      chk("mult_busy_ready", 64'(r1), 64'd0);
      chk("mult_res", {hi0, res0}, {32'hFFFFFFFE, 32'd1});

      issue(1'b1, DIVO, 32'd100, 32'd7);
      wait_valid(0, -1, 80, lat, r1);
      chk("div_latency", 64'(lat), 64'd32);
      chk("div_res", {31'd0, dz0, hi0, res0}, {32'd0, 32'd2, 32'd14});

      issue(1'b1, DIVO, 32'd100, 32'd0);
      wait_valid(0, -1, 80, lat, r1);
      chk("div0_latency", 64'(lat), 64'd1);
      chk("div0_res", {31'd0, dz0, hi0, res0}, {31'd0, 1'b1, 32'd100, 32'hFFFFFFFF});
      issue(1'b1, ADD, 32'd1, 32'd1);
      wait_valid(0, -1, 80, lat, r1);
      chk("div0_clear", {31'd0, dz0, res0}, {32'd0, 32'd2});

      issue(1'b1, SLT, 32'hFFFFFFFF, 32'd1);
      wait_valid(0, -1, 80, lat, r1);
      chk("slt_unsigned", {32'd0, res0}, 64'd0);
      chk("slt_signed", {32'd0, res1}, 64'd1);

      // Reset aborting an 8-bit multiply.
      issue(1'b1, ADD, 32'd3, 32'd4);
      wait_valid(2, -1, 80, lat, r1);
      chk("pre_reset_res8", 64'(res2), 64'd7);
      issue(1'b1, MULT, 32'h10, 32'h10);
      @(posedge clock);
      #1 start = 1'b0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_out8", {38'd0, vld2, rdy2, z2, dz2, il2, 5'd0, res2, hi2}, {38'd0, 5'b01000, 5'd0, 16'd0});
      @(negedge clock);
      reset = 1'b0;
      npulse = 0;
      repeat (20) begin
         @(posedge clock);
         #1;
         if (vld2) npulse++;
      end
      chk("no_valid_after_abort", 64'(npulse), 64'd0);
      issue(1'b1, 6'b000000, 32'd5, 32'd6);
      wait_valid(2, -1, 80, lat, r1);
      chk("illegal8_latency", 64'(lat), 64'd1);
      chk("illegal8", {45'd0, il2, z2, res2, hi2}, {45'd0, 2'b11, 16'd0});

      // Random traffic with operand churn and one mid-stream reset.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clock);
         #1;
         start = ($urandom_range(0, 9) < 7);
         selector = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
         input1 = rnd_op();
         input2 = rnd_op();
         if (i == 1500) begin
            reset = 1'b1;
            #2 reset = 1'b0;
         end
      end
      start = 1'b0;
      repeat (40) @(posedge clock);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
